// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: channel FSM states, perf counter width
// and the consumer-index width helper.
package data_mem_arbiter_pkg;

  localparam int PERF_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } chan_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arb_channel.sv
// One memory channel: IDLE/READ_WAIT/WRITE_WAIT/RELAY FSM plus the registered
// consumer index, address and write data of the transaction it owns.
module data_mem_arb_channel
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic                 grant_write,
  input  logic [IDX_W-1:0]     grant_idx,
  input  logic [ADDR_BITS-1:0] grant_addr,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 cons_valid,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_ready,
  output logic                 idle,
  output logic                 done,
  output logic [IDX_W-1:0]     idx,
  output logic                 mem_read_valid,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 cons_read_ready,
  output logic                 cons_write_ready,
  output logic [DATA_BITS-1:0] cons_read_data
);

  chan_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory ready only counts once our valid is actually on the bus.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (grant) state_next = grant_write ? WRITE_WAIT : READ_WAIT;
      READ_WAIT:  if (mem_read_valid && mem_read_ready) state_next = RELAY;
      WRITE_WAIT: if (mem_write_valid && mem_write_ready) state_next = RELAY;
      RELAY:      if (!cons_valid) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  assign idle = (state == IDLE);
  assign done = (state == RELAY) && !cons_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx              <= '0;
      mem_read_valid   <= 1'b0;
      mem_write_valid  <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      cons_read_ready  <= 1'b0;
      cons_write_ready <= 1'b0;
      cons_read_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            idx       <= grant_idx;
            mem_addr  <= grant_addr;
            mem_wdata <= grant_data;
          end
        end
        READ_WAIT: begin
          if (!mem_read_valid) mem_read_valid <= 1'b1;
          else if (mem_read_ready) begin
            mem_read_valid  <= 1'b0;
            cons_read_data  <= mem_read_data;
            cons_read_ready <= 1'b1;
          end
        end
        WRITE_WAIT: begin
          if (!mem_write_valid) mem_write_valid <= 1'b1;
          else if (mem_write_ready) begin
            mem_write_valid  <= 1'b0;
            cons_write_ready <= 1'b1;
          end
        end
        RELAY: begin
          if (!cons_valid) begin
            cons_read_ready  <= 1'b0;
            cons_write_ready <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSUs with ordered
// round-robin grant. Optional perf counters under DATA_MEM_ARBITER_PERF_EN.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 16,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]           mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_ready
`ifdef DATA_MEM_ARBITER_PERF_EN
  ,
  output logic [PERF_W-1:0]                 perf_grants,
  output logic [PERF_W-1:0]                 perf_stall_cycles,
  input  logic                              perf_clear
`endif
);

  localparam int IDX_W = idx_w(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0] req, claim, claim_next, taken;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] rr_ptr, pick, idx;
  logic [NUM_CHANNELS-1:0] grant, grant_write, idle, done, cons_valid, rd_rdy, wr_rdy;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] grant_addr, chan_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] grant_data, chan_wdata, rd_data;

  assign req = consumer_read_valid | consumer_write_valid;

  // Channels pick in index order; each pick is hidden from higher channels.
  always_comb begin
    int cand;
    cand  = 0;
    taken = claim;
    grant = '0;
    pick  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (idle[c]) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          cand = (int'(rr_ptr[c]) + k) % NUM_CONSUMERS;
          if (!grant[c] && req[cand] && !taken[cand]) begin
            grant[c] = 1'b1;
            pick[c]  = IDX_W'(cand);
          end
        end
        if (grant[c]) taken[pick[c]] = 1'b1;
      end
    end
  end

  always_comb begin
    claim_next = claim;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c]) claim_next[pick[c]] = 1'b1;
      if (done[c])  claim_next[idx[c]]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      claim  <= '0;
      rr_ptr <= '0;
    end else begin
      claim <= claim_next;
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (grant[c])
          rr_ptr[c] <= (int'(pick[c]) == NUM_CONSUMERS - 1) ? '0 : pick[c] + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign grant_write[c] = consumer_write_valid[pick[c]];
    assign grant_addr[c]  = consumer_write_valid[pick[c]]
                          ? consumer_write_address[pick[c]*ADDR_BITS +: ADDR_BITS]
                          : consumer_read_address[pick[c]*ADDR_BITS +: ADDR_BITS];
    assign grant_data[c]  = consumer_write_data[pick[c]*DATA_BITS +: DATA_BITS];
    assign cons_valid[c]  = req[idx[c]];

    data_mem_arb_channel #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .IDX_W    (IDX_W)
    ) u_chan (
      .clk             (clk),
      .reset           (reset),
      .grant           (grant[c]),
      .grant_write     (grant_write[c]),
      .grant_idx       (pick[c]),
      .grant_addr      (grant_addr[c]),
      .grant_data      (grant_data[c]),
      .cons_valid      (cons_valid[c]),
      .mem_read_ready  (mem_read_ready[c]),
      .mem_read_data   (mem_read_data[c*DATA_BITS +: DATA_BITS]),
      .mem_write_ready (mem_write_ready[c]),
      .idle            (idle[c]),
      .done            (done[c]),
      .idx             (idx[c]),
      .mem_read_valid  (mem_read_valid[c]),
      .mem_write_valid (mem_write_valid[c]),
      .mem_addr        (chan_addr[c]),
      .mem_wdata       (chan_wdata[c]),
      .cons_read_ready (rd_rdy[c]),
      .cons_write_ready(wr_rdy[c]),
      .cons_read_data  (rd_data[c])
    );

    assign mem_read_address[c*ADDR_BITS +: ADDR_BITS]  = chan_addr[c];
    assign mem_write_address[c*ADDR_BITS +: ADDR_BITS] = chan_addr[c];
    assign mem_write_data[c*DATA_BITS +: DATA_BITS]    = chan_wdata[c];
  end

  // A consumer owns at most one channel, so plain OR-steering is safe.
  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    consumer_read_data   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rd_rdy[c]) begin
        consumer_read_ready[idx[c]] = 1'b1;
        consumer_read_data[idx[c]*DATA_BITS +: DATA_BITS] = rd_data[c];
      end
      if (wr_rdy[c]) consumer_write_ready[idx[c]] = 1'b1;
    end
  end

`ifdef DATA_MEM_ARBITER_PERF_EN
  logic [PERF_W:0] grant_sum;

  always_comb begin
    grant_sum = {1'b0, perf_grants};
    for (int c = 0; c < NUM_CHANNELS; c++)
      grant_sum = grant_sum + (PERF_W+1)'(grant[c]);
  end

  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_grants       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_grants <= grant_sum[PERF_W] ? '1 : grant_sum[PERF_W-1:0];
      if (|(req & ~claim) && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS load/store units (one per thread across all cores).
- Sits between the per-thread LSUs and the external data-memory ports of the gpu top level.
- Uses one FSM per channel and round-robin grant, with a valid/ready relay handshake on both sides.
- Guarantees every consumer request is served exactly once, with bounded wait.

Parameters:
- ADDR_BITS, 8, data memory address width.
- DATA_BITS, 8, data memory word width.
- NUM_CONSUMERS, 16, number of requesters (CORES*THREADS).
- NUM_CHANNELS, 4, number of memory channels; must be ≤ NUM_CONSUMERS.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  read addresses.
- consumer_read_ready  out  NUM_CONSUMERS  read done, data valid.
- consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  returned data, held while ready.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  write addresses.
- consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  write data.
- consumer_write_ready  out  NUM_CONSUMERS  write acknowledged.
- mem_read_valid  out  NUM_CHANNELS  channel read request.
- mem_read_address  out  NUM_CHANNELS x ADDR_BITS  channel read address.
- mem_read_ready  in  NUM_CHANNELS  memory read done.
- mem_read_data  in  NUM_CHANNELS x DATA_BITS  memory read data.
- mem_write_valid  out  NUM_CHANNELS  channel write request.
- mem_write_address  out  NUM_CHANNELS x ADDR_BITS  channel write address.
- mem_write_data  out  NUM_CHANNELS x DATA_BITS  channel write data.
- mem_write_ready  in  NUM_CHANNELS  memory write done.

Behaviour:
- Reset:
  - All outputs are 0.
  - Every channel FSM is IDLE.
  - All consumer-claim bits are cleared.
  - All round-robin pointers are 0.
  - A reset mid-transaction abandons the transaction; the consumer must re-request.
- Consumer contract:
  - Holds valid and address/data stable until its ready is seen.
  - Then drops valid.
  - Never asserts read and write valid together.
- Channel states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan consumers starting at rr_ptr[c], wrapping modulo NUM_CONSUMERS.
  - Pick the first consumer that has read or write valid and is not claimed.
  - Register the claim, consumer index, and address/data.
  - Next cycle, assert mem_read_valid or mem_write_valid.
  - Set rr_ptr[c] = granted+1, wrapping to 0.
  - If no request is pending, stay in IDLE.
- Same-cycle grants: channels resolve in index order (channel 0 first); a lower channel's same-cycle pick is excluded for higher channels. A consumer never holds two channels.
- READ_WAIT: on mem_read_ready, latch data into consumer_read_data, assert consumer_read_ready, drop mem_read_valid, go to RELAY.
- WRITE_WAIT: same as READ_WAIT, using mem_write_ready / consumer_write_ready and no data.
- RELAY:
  - Hold consumer ready until that consumer's valid is low.
  - Then clear ready and the claim, and go to IDLE.
  - The released consumer may be re-granted no earlier than the cycle after that return.
- Latency: request visible → mem valid is 2 cycles (grant register, then output). Mem ready → consumer ready is 1 cycle.
- Fairness: with all consumers requesting continuously, no consumer waits more than ceil(NUM_CONSUMERS/NUM_CHANNELS) grants.
- Memory-side valid stays high until the matching ready. Address and data are stable during the wait.
- Mem ready arriving in IDLE or RELAY is ignored.

Optional Feature:
- Macro: DATA_MEM_ARBITER_PERF_EN.
- When defined, adds ports:
  - perf_grants (out, 32): total grants.
  - perf_stall_cycles (out, 32): cycles where at least one consumer's valid is high but unclaimed.
  - perf_clear (in, 1): synchronous clear of both counters.
- Counter rules: both counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package data_mem_arbiter_pkg holds:
  - The channel-state enum chan_state_t {IDLE, READ_WAIT, WRITE_WAIT, RELAY}.
  - The counter width constant PERF_W=32.
- Sub-module data_mem_arb_channel holds one channel FSM plus its address/data/index registers.
- The top level holds the claim vector, the ordered round-robin pick, and the output muxing.

Test Plan:
- Single read: consumer 3 reads addr 0x05 (mem holds 0x05), memory latency 1 → mem_read_valid[0] high 2 cycles after request; consumer_read_ready[3] high with data 0x05; channel back to IDLE after valid drops.
- Contention: 8 consumers read addr i, 4 channels → channels 0-3 granted consumers 0-3 in the same cycle, then 4-7; all data correct; no consumer double-claimed.
- Mixed write/read (matadd-style): 8 consumers write A[i]+B[i] to addr 16+i, then read back → memory[16..23] = 0,2,4,…,14.
- Fairness: consumers 0-15 request continuously for 200 cycles → every consumer granted; no wait exceeds 4 grants.
- Reset mid-transaction: assert reset while channel 1 is in READ_WAIT → next cycle all outputs 0; a subsequent request is served normally.
- With DATA_MEM_ARBITER_PERF_EN defined, 8 reads → perf_grants = 8; pulsing perf_clear → 0.
